// File: rtl/sat_add_rr_scheduler.sv
// ---------------------------------------------------------------------------
// sat_add_rr_scheduler
//
// Shares one W-bit signed saturating adder between N_REQ requesters. A
// rotating-priority arbiter picks one operand pair per cycle. The clamped sum
// is captured in a single output register. That register has a valid/ready
// handshake and carries the requester id and a saturation flag.
//
// Parameters:
//   N_REQ  number of requesters (>= 2)
//   W      operand/result width, two's complement (>= 2)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  [N_REQ]    per-requester operand valid
//   req_ready  [N_REQ]    per-requester accept (one-hot or zero)
//   req_a      [N_REQ*W]  packed operand a, requester i at [i*W +: W]
//   req_b      [N_REQ*W]  packed operand b, same packing
//   res_valid  result register holds an unconsumed result
//   res_ready  consumer accepts the result
//   res_sum    [W]        saturated signed sum
//   res_id     [clog2(N_REQ)] requester that produced res_sum
//   res_sat    res_sum was clamped
//   sat_count  [8]        saturating-transfer counter, sticks at 255
//                         (present only when SAT_ADD_RR_SAT_STATS_EN is defined)
// ---------------------------------------------------------------------------
module sat_add_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int W     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*W-1:0]         req_a,
    input  logic [N_REQ*W-1:0]         req_b,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [W-1:0]               res_sum,
    output logic [$clog2(N_REQ)-1:0]   res_id,
    output logic                       res_sat
`ifdef SAT_ADD_RR_SAT_STATS_EN
    ,
    output logic [7:0]                 sat_count
`endif
);

    localparam int          ID_W    = $clog2(N_REQ);
    localparam int unsigned N_REQ_U = N_REQ;

    logic [ID_W-1:0]  rr_ptr;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_any;
    logic [W-1:0]     a_sel;
    logic [W-1:0]     b_sel;
    logic [W-1:0]     sum_raw;
    logic             ovf;
    logic [W-1:0]     sum_sat;
    logic             accept;
    logic             xfer;
    logic [ID_W-1:0]  ptr_next;

    // ---------------------------------------------------------------
    // Rotating-priority grant. The search starts at rr_ptr and walks
    // upward modulo N_REQ. The first valid requester found wins and
    // its operands are muxed onto the shared adder.
    // ---------------------------------------------------------------
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        a_sel     = '0;
        b_sel     = '0;
        for (int unsigned k = 0; k < N_REQ_U; k++) begin
            int unsigned idx;
            idx = (32'(rr_ptr) + k) % N_REQ_U;
            if (!grant_any && req_valid[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
                a_sel      = req_a[idx*W +: W];
                b_sel      = req_b[idx*W +: W];
            end
        end
    end

    // ---------------------------------------------------------------
    // Saturating adder. Overflow is only possible when both operands
    // have the same sign and the wrapped sum flips it. The clamp
    // direction then follows the operand sign.
    // ---------------------------------------------------------------
    always_comb begin
        sum_raw = a_sel + b_sel;
        ovf     = (a_sel[W-1] == b_sel[W-1]) && (sum_raw[W-1] != a_sel[W-1]);
        if (ovf) begin
            sum_sat = a_sel[W-1] ? {1'b1, {(W-1){1'b0}}}
                                 : {1'b0, {(W-1){1'b1}}};
        end else begin
            sum_sat = sum_raw;
        end
    end

    // ---------------------------------------------------------------
    // Handshake. The output register may reload in the same cycle the
    // old result drains. rst_n gates req_ready so nothing is offered
    // while the block is held in reset.
    // ---------------------------------------------------------------
    always_comb begin
        accept    = !res_valid || res_ready;
        req_ready = grant & {N_REQ{accept && rst_n}};
        xfer      = grant_any && accept;
        if (grant_idx == ID_W'(N_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + ID_W'(1);
        end
    end

    // ---------------------------------------------------------------
    // Result register and round-robin pointer. The pointer only moves
    // on a transfer, to the slot just past the winner.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_id    <= '0;
            res_sat   <= 1'b0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            res_valid <= 1'b1;
            res_sum   <= sum_sat;
            res_id    <= grant_idx;
            res_sat   <= ovf;
            rr_ptr    <= ptr_next;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

`ifdef SAT_ADD_RR_SAT_STATS_EN
    // Saturation statistics: counts clamped transfers, sticks at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (xfer && ovf && (sat_count != '1)) begin
            sat_count <= sat_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sat_add_rr_scheduler.sv
module tb_sat_add_rr_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_sum;
    logic [1:0]  res_id;
    logic        res_sat;
`ifdef SAT_ADD_RR_SAT_STATS_EN
    logic [7:0]  sat_count;
`endif

    int errors = 0;
    int checks = 0;

    sat_add_rr_scheduler #(.N_REQ(4), .W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .res_sat   (res_sat)
`ifdef SAT_ADD_RR_SAT_STATS_EN
        ,
        .sat_count (sat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  v;
        logic [15:0] a;
        logic [15:0] b;
        logic        rr;
        logic [3:0]  e_ready;
        logic        e_valid;
        logic [3:0]  e_sum;
        logic [1:0]  e_id;
        logic        e_sat;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [15:0] pk(int x0, int x1, int x2, int x3);
        return {4'(x3), 4'(x2), 4'(x1), 4'(x0)};
    endfunction

    function automatic vec_t mk(logic [3:0] v, logic [15:0] a, logic [15:0] b,
                                logic rr, logic [3:0] er, logic ev,
                                int es, int ei, logic esat);
        vec_t r;
        r.v = v; r.a = a; r.b = b; r.rr = rr;
        r.e_ready = er; r.e_valid = ev;
        r.e_sum = 4'(es); r.e_id = 2'(ei); r.e_sat = esat;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin : main
        logic [15:0] fa;
        logic [15:0] fb;
        fa = pk(1, 2, 3, 7);
        fb = pk(1, -1, -8, 7);

        // Single requester 2: positive clamp, mixed signs, negative clamp.
        tbl.push_back(mk(4'b0100, pk(0,0,3,0),  pk(0,0,6,0),  1, 4'b0100, 1,  7, 2, 1));
        tbl.push_back(mk(4'b0100, pk(0,0,4,0),  pk(0,0,-4,0), 1, 4'b0100, 1,  0, 2, 0));
        tbl.push_back(mk(4'b0100, pk(0,0,-4,0), pk(0,0,-7,0), 1, 4'b0100, 1, -8, 2, 1));
        tbl.push_back(mk(4'b0100, pk(0,0,-3,0), pk(0,0,5,0),  1, 4'b0100, 1,  2, 2, 0));
        // Drain with nothing new: valid drops, payload holds.
        tbl.push_back(mk(4'b0000, '0, '0, 1, 4'b0000, 0, 2, 2, 0));
        // Requester 3 moves the pointer back to 0.
        tbl.push_back(mk(4'b1000, pk(0,0,0,1), pk(0,0,0,1), 1, 4'b1000, 1, 2, 3, 0));
        // Fairness with all four requesting.
        tbl.push_back(mk(4'b1111, fa, fb, 1, 4'b0001, 1,  2, 0, 0));
        tbl.push_back(mk(4'b1111, fa, fb, 1, 4'b0010, 1,  1, 1, 0));
        tbl.push_back(mk(4'b1111, fa, fb, 1, 4'b0100, 1, -5, 2, 0));
        tbl.push_back(mk(4'b1111, fa, fb, 1, 4'b1000, 1,  7, 3, 1));
        tbl.push_back(mk(4'b1111, fa, fb, 1, 4'b0001, 1,  2, 0, 0));
        tbl.push_back(mk(4'b1111, fa, fb, 1, 4'b0010, 1,  1, 1, 0));
        tbl.push_back(mk(4'b1111, fa, fb, 1, 4'b0100, 1, -5, 2, 0));
        tbl.push_back(mk(4'b1111, fa, fb, 1, 4'b1000, 1,  7, 3, 1));
        // Sparse requesters 1 and 3 alternate.
        tbl.push_back(mk(4'b1010, fa, fb, 1, 4'b0010, 1,  1, 1, 0));
        tbl.push_back(mk(4'b1010, fa, fb, 1, 4'b1000, 1,  7, 3, 1));
        tbl.push_back(mk(4'b1010, fa, fb, 1, 4'b0010, 1,  1, 1, 0));
        tbl.push_back(mk(4'b1010, fa, fb, 1, 4'b1000, 1,  7, 3, 1));
        // Backpressure for 3 cycles: nothing granted, outputs stable.
        tbl.push_back(mk(4'b1010, fa, fb, 0, 4'b0000, 1,  7, 3, 1));
        tbl.push_back(mk(4'b1010, fa, fb, 0, 4'b0000, 1,  7, 3, 1));
        tbl.push_back(mk(4'b1010, fa, fb, 0, 4'b0000, 1,  7, 3, 1));
        // Release: drain and reload in the same cycle.
        tbl.push_back(mk(4'b1010, fa, fb, 1, 4'b0010, 1,  1, 1, 0));
        tbl.push_back(mk(4'b0000, fa, fb, 1, 4'b0000, 0,  1, 1, 0));
        // Empty register accepts even with res_ready=0, then stalls.
        tbl.push_back(mk(4'b0001, fa, fb, 0, 4'b0001, 1,  2, 0, 0));
        tbl.push_back(mk(4'b0001, fa, fb, 0, 4'b0000, 1,  2, 0, 0));

        // Reset with every requester asserting.
        rst_n = 1'b0; req_valid = 4'b1111; req_a = fa; req_b = fb; res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        chk("reset_res_valid", 32'(res_valid), 32'h0);
        chk("reset_res_sum",   32'(res_sum),   32'h0);
        chk("reset_res_id",    32'(res_id),    32'h0);
        chk("reset_res_sat",   32'(res_sat),   32'h0);
`ifdef SAT_ADD_RR_SAT_STATS_EN
        chk("reset_sat_count", 32'(sat_count), 32'h0);
`endif
        @(negedge clk);
        req_valid = 4'b0000;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            req_valid = tbl[i].v; req_a = tbl[i].a; req_b = tbl[i].b;
            res_ready = tbl[i].rr;
            #1;
            chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_res_valid", i), 32'(res_valid), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d_res_sum", i),   32'(res_sum),   32'(tbl[i].e_sum));
            chk($sformatf("v%0d_res_id", i),    32'(res_id),    32'(tbl[i].e_id));
            chk($sformatf("v%0d_res_sat", i),   32'(res_sat),   32'(tbl[i].e_sat));
        end

        // Async reset mid-cycle with a result pending (res_valid=1, pointer=1).
        @(negedge clk);
        req_valid = 4'b0000; res_ready = 1'b0;
        #2;
        chk("pre_arst_res_valid", 32'(res_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_res_valid_now", 32'(res_valid), 32'h0);
        chk("arst_res_sum_now",   32'(res_sum),   32'h0);
        req_valid = 4'b1111; res_ready = 1'b1;
        #1;
        chk("arst_req_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_arst_grant", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("post_arst_res_valid", 32'(res_valid), 32'h1);
        chk("post_arst_res_id",    32'(res_id),    32'h0);
        chk("post_arst_res_sum",   32'(res_sum),   32'h2);

`ifdef SAT_ADD_RR_SAT_STATS_EN
        // Reset clears the counter, then 300 clamped transfers stick at 255.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req_valid = 4'b0001; req_a = pk(7,0,0,0); req_b = pk(7,0,0,0); res_ready = 1'b1;
        #1;
        chk("stats_after_reset", 32'(sat_count), 32'h0);
        repeat (300) @(posedge clk);
        #1;
        chk("stats_res_sat", 32'(res_sat), 32'h1);
        chk("stats_sat_count_sticky", 32'(sat_count), 32'd255);
        req_valid = 4'b0000;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog: the test is purely time-driven, this only guards against a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
